kgp_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the KGP-RISC datapath; successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and issues per-state strobes to the datapath.
- Adds a valid/ready data-memory handshake with timeout, flag-based branch resolution, a trap state and a retired-instruction counter.
- Sits between the instruction register/flags and the PC, register file, ALU and data-memory port.

---
 rtl/kgp_ctrl_pkg.sv | 26 ++
 rtl/kgp_branch_resolve.sv | 21 ++
 rtl/kgp_multicycle_ctrl.sv | 135 +++++++++++++
 tb/tb_kgp_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/kgp_ctrl_pkg.sv
// kgp_ctrl_pkg: shared states, opcode classes and control-field encodings for the KGP-RISC multi-cycle controller
package kgp_ctrl_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_ITYPE = 3'd1;
  localparam logic [2:0] OP_LW = 3'd2;
  localparam logic [2:0] OP_SW = 3'd3;
  localparam logic [2:0] OP_B = 3'd4;
  localparam logic [2:0] OP_BC = 3'd5;
  localparam logic [2:0] OP_BR = 3'd6;
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;
  localparam logic [1:0] RD_RS = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_FUNCT = 2'b01;
  localparam logic [1:0] ALU_CMP = 2'b10;
  localparam logic [1:0] TC_NONE = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_BUS = 2'b10;
endpackage

// File: rtl/kgp_branch_resolve.sv
// kgp_branch_resolve: combinational branch-taken, link and illegal-instruction decode from opcode class, funct[1:0] and ALU flags
module kgp_branch_resolve
  import kgp_ctrl_pkg::*;
(
  input  logic [2:0] op_cls,
  input  logic       op_high,
  input  logic [1:0] fn,
  input  logic       flag_zero,
  input  logic       flag_neg,
  input  logic       flag_carry,
  output logic       taken,
  output logic       link,
  output logic       illegal
);
  logic b_taken, bc_taken;
  assign b_taken = !fn[1] || (fn[0] ^ flag_carry);
  assign bc_taken = fn == 2'd0 ? flag_neg : fn == 2'd1 ? flag_zero : fn == 2'd2 ? !flag_zero : 1'b0;
  assign taken = op_cls == OP_BR || (op_cls == OP_B && b_taken) || (op_cls == OP_BC && bc_taken);
  assign link = op_cls == OP_B && fn == 2'd1;
  assign illegal = op_high || op_cls == 3'd7 || (op_cls == OP_BC && fn == 2'd3);
endmodule

// File: rtl/kgp_multicycle_ctrl.sv
// kgp_multicycle_ctrl: multi-cycle KGP-RISC control FSM with memory handshake timeout, trap state and retired-instruction counter
module kgp_multicycle_ctrl
  import kgp_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                flag_zero,
  input  logic                flag_neg,
  input  logic                flag_carry,
  input  logic                stall,
  input  logic                mem_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src,
  output logic [1:0]          alu_op,
  output logic                memRead,
  output logic                memWrite,
  output logic                regWrite,
  output logic [1:0]          regDst,
  output logic [1:0]          mem2Reg,
  output logic                branch,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    instret
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  state_t state, state_n;
  logic [OPCODE_W-1:0] opcode_q, sel_op;
  logic [1:0] fn_q, sel_fn, cause_q;
  logic [CW-1:0] wait_cnt;
  logic taken, link, illegal, retire, unused_funct;
  logic is_rtype, is_itype, is_lw, is_sw;
  assign sel_op = state == DECODE ? opcode : opcode_q;
  assign sel_fn = state == DECODE ? funct[1:0] : fn_q;
  assign unused_funct = ^funct;
  assign is_rtype = opcode_q[2:0] == OP_RTYPE;
  assign is_itype = opcode_q[2:0] == OP_ITYPE;
  assign is_lw = opcode_q[2:0] == OP_LW;
  assign is_sw = opcode_q[2:0] == OP_SW;
  assign trap_cause = cause_q;
  kgp_branch_resolve u_resolve (
    .op_cls    (sel_op[2:0]),
    .op_high   (|sel_op[OPCODE_W-1:3]),
    .fn        (sel_fn),
    .flag_zero (flag_zero),
    .flag_neg  (flag_neg),
    .flag_carry(flag_carry),
    .taken     (taken),
    .link      (link),
    .illegal   (illegal)
  );
  always_comb begin
    state_n = state;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = PC_SEQ;
    alu_src = 1'b0;
    alu_op = ALU_ADD;
    memRead = 1'b0;
    memWrite = 1'b0;
    regWrite = 1'b0;
    regDst = RD_RS;
    mem2Reg = M2R_ALU;
    branch = 1'b0;
    trap = 1'b0;
    retire = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: if (!stall) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_n = DECODE;
        end
        DECODE: state_n = illegal ? TRAP : EXEC;
        EXEC: if (is_lw || is_sw) begin
          alu_src = 1'b1;
          state_n = MEM;
        end else if (is_rtype || is_itype) begin
          alu_src = is_itype;
          alu_op = ALU_FUNCT;
          state_n = WB;
        end else begin
          branch = 1'b1;
          alu_op = ALU_CMP;
          pc_write = taken;
          pc_src = opcode_q[2:0] == OP_BR ? PC_REG : PC_BRANCH;
          state_n = link ? WB : FETCH;
          retire = !link;
        end
        MEM: begin
          memRead = is_lw;
          memWrite = is_sw;
          state_n = mem_ready ? (is_lw ? WB : FETCH) : wait_cnt == CW'(MEM_TIMEOUT) ? TRAP : MEM;
          retire = mem_ready && is_sw;
        end
        WB: begin
          regWrite = 1'b1;
          regDst = is_rtype ? RD_RS : link ? RD_R31 : RD_RT;
          mem2Reg = is_lw ? M2R_MEM : link ? M2R_PC4 : M2R_ALU;
          retire = 1'b1;
          state_n = FETCH;
        end
        TRAP: trap = 1'b1;
        default: state_n = FETCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      opcode_q <= '0;
      fn_q <= '0;
      cause_q <= TC_NONE;
      instret <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == DECODE) begin
        opcode_q <= opcode;
        fn_q <= funct[1:0];
      end
      if (state != TRAP && state_n == TRAP) cause_q <= state == MEM ? TC_BUS : TC_ILLEGAL;
      if (retire) instret <= instret + CNT_W'(1);
      wait_cnt <= state == MEM && state_n == MEM ? wait_cnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
// tb_kgp_multicycle_ctrl: scoreboard-driven directed bench for the multi-cycle controller
module tb_kgp_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst, stall, mem_ready, flag_zero, flag_neg, flag_carry;
  logic [5:0] opcode;
  logic [4:0] funct;
  logic ir_write, pc_write, alu_src, memRead, memWrite, regWrite, branch, trap;
  logic [1:0] pc_src, alu_op, regDst, mem2Reg, trap_cause;
  logic [31:0] instret;
  logic [17:0] obs_v;
  always #5 clk = ~clk;
  kgp_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .flag_zero(flag_zero), .flag_neg(flag_neg), .flag_carry(flag_carry),
    .stall(stall), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op),
    .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite), .regDst(regDst), .mem2Reg(mem2Reg),
    .branch(branch), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );
  assign obs_v = {ir_write, pc_write, pc_src, alu_src, alu_op, memRead, memWrite, regWrite,
                  regDst, mem2Reg, branch, trap, trap_cause};
  typedef struct {
    string tag;
    logic chk, r, s, rdy, z, n, c;
    logic [5:0] op;
    logic [4:0] fn;
    logic [17:0] exp;
    logic [31:0] ret;
  } step_t;
  step_t q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] ret_m = 32'd0;
  logic [5:0] cur_op = 6'd0;
  logic [4:0] cur_fn = 5'd0;
  logic cz = 1'b0, cn = 1'b0, cc = 1'b0;
  function automatic logic [17:0] ov(input logic ir, input logic pcw, input logic [1:0] pcs, input logic as,
                                     input logic [1:0] aop, input logic mr, input logic mw, input logic rw,
                                     input logic [1:0] rd, input logic [1:0] m2r, input logic br,
                                     input logic tr, input logic [1:0] tc);
    return {ir, pcw, pcs, as, aop, mr, mw, rw, rd, m2r, br, tr, tc};
  endfunction
  function automatic logic [17:0] fetch_v();
    return ov(1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
  endfunction
  function automatic logic [17:0] alu_v(input logic as, input logic [1:0] aop);
    return ov(1'b0, 1'b0, 2'b00, as, aop, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
  endfunction
  function automatic logic [17:0] br_v(input logic pcw, input logic [1:0] pcs);
    return ov(1'b0, pcw, pcs, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00);
  endfunction
  function automatic logic [17:0] mem_v(input logic mr, input logic mw);
    return ov(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, mr, mw, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
  endfunction
  function automatic logic [17:0] wb_v(input logic [1:0] rd, input logic [1:0] m2r);
    return ov(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, rd, m2r, 1'b0, 1'b0, 2'b00);
  endfunction
  function automatic logic [17:0] trap_v(input logic [1:0] tc);
    return ov(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, tc);
  endfunction
  task automatic step(input string tag, input logic chk, input logic r, input logic s, input logic rdy,
                      input logic [17:0] e);
    step_t t;
    t.tag = tag;
    t.chk = chk;
    t.r = r;
    t.s = s;
    t.rdy = rdy;
    t.z = cz;
    t.n = cn;
    t.c = cc;
    t.op = cur_op;
    t.fn = cur_fn;
    t.exp = e;
    t.ret = ret_m;
    q.push_back(t);
  endtask
  task automatic start(input string nm, input logic [5:0] op, input logic [4:0] fn,
                       input logic z, input logic n, input logic c);
    cur_op = op;
    cur_fn = fn;
    cz = z;
    cn = n;
    cc = c;
    step({nm, ".fetch"}, 1'b1, 1'b0, 1'b0, 1'b0, fetch_v());
    step({nm, ".decode"}, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask
  task automatic do_reset(input string nm);
    step({nm, ".rst0"}, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    ret_m = 32'd0;
    step({nm, ".rst1"}, 1'b1, 1'b1, 1'b1, 1'b0, '0);
  endtask
  task automatic br_case(input string nm, input logic [5:0] op, input logic [4:0] fn, input logic z,
                         input logic n, input logic c, input logic pcw, input logic [1:0] pcs);
    start(nm, op, fn, z, n, c);
    step({nm, ".exec"}, 1'b1, 1'b0, 1'b0, 1'b0, br_v(pcw, pcs));
    ret_m = ret_m + 32'd1;
  endtask
  task automatic rtype(input string nm);
    start(nm, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step({nm, ".exec"}, 1'b1, 1'b0, 1'b0, 1'b0, alu_v(1'b0, 2'b01));
    step({nm, ".wb"}, 1'b1, 1'b0, 1'b0, 1'b0, wb_v(2'b00, 2'b00));
    ret_m = ret_m + 32'd1;
  endtask
  task automatic run();
    step_t t;
    while (q.size() > 0) begin
      t = q.pop_front();
      rst = t.r;
      stall = t.s;
      mem_ready = t.rdy;
      opcode = t.op;
      funct = t.fn;
      flag_zero = t.z;
      flag_neg = t.n;
      flag_carry = t.c;
      @(negedge clk);
      if (t.chk) begin
        checks++;
        assert (obs_v === t.exp) else begin
          errors++;
          $error("FAIL %s outputs got %b want %b", t.tag, obs_v, t.exp);
        end
        checks++;
        assert (instret === t.ret) else begin
          errors++;
          $error("FAIL %s instret got %0d want %0d", t.tag, instret, t.ret);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    rst = 1'b1;
    stall = 1'b1;
    mem_ready = 1'b0;
    flag_zero = 1'b0;
    flag_neg = 1'b0;
    flag_carry = 1'b0;
    opcode = 6'd0;
    funct = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 1'b1, 1'b1, 1'b1, 1'b0, '0);
    step("reset", 1'b1, 1'b1, 1'b1, 1'b0, '0);
    rtype("rtype");
    start("itype", 6'd1, 5'd0, 1'b0, 1'b0, 1'b0);
    step("itype.exec", 1'b1, 1'b0, 1'b0, 1'b0, alu_v(1'b1, 2'b01));
    step("itype.wb", 1'b1, 1'b0, 1'b0, 1'b0, wb_v(2'b01, 2'b00));
    ret_m = ret_m + 32'd1;
    start("lw", 6'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    step("lw.exec", 1'b1, 1'b0, 1'b0, 1'b0, alu_v(1'b1, 2'b00));
    repeat (3) step("lw.mem", 1'b1, 1'b0, 1'b0, 1'b0, mem_v(1'b1, 1'b0));
    step("lw.mem_rdy", 1'b1, 1'b0, 1'b0, 1'b1, mem_v(1'b1, 1'b0));
    step("lw.wb", 1'b1, 1'b0, 1'b0, 1'b0, wb_v(2'b01, 2'b01));
    ret_m = ret_m + 32'd1;
    start("sw", 6'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    step("sw.exec", 1'b1, 1'b0, 1'b0, 1'b0, alu_v(1'b1, 2'b00));
    step("sw.mem_rdy", 1'b1, 1'b0, 1'b0, 1'b1, mem_v(1'b0, 1'b1));
    ret_m = ret_m + 32'd1;
    br_case("bcy_c0", 6'd4, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    br_case("bcy_c1", 6'd4, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
    br_case("bncy_c0", 6'd4, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    br_case("b", 6'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    br_case("bc_neg", 6'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    br_case("bc_z", 6'd5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    br_case("bc_nz", 6'd5, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    br_case("br", 6'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    start("bl", 6'd4, 5'd1, 1'b0, 1'b0, 1'b0);
    step("bl.exec", 1'b1, 1'b0, 1'b0, 1'b0, br_v(1'b1, 2'b01));
    step("bl.wb", 1'b1, 1'b0, 1'b0, 1'b0, wb_v(2'b10, 2'b10));
    ret_m = ret_m + 32'd1;
    cur_op = 6'd0;
    repeat (5) step("stall.fetch", 1'b1, 1'b0, 1'b1, 1'b0, '0);
    start("stall", 6'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("stall.exec", 1'b1, 1'b0, 1'b1, 1'b0, alu_v(1'b0, 2'b01));
    step("stall.wb", 1'b1, 1'b0, 1'b0, 1'b0, wb_v(2'b00, 2'b00));
    ret_m = ret_m + 32'd1;
    start("lw_edge", 6'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    step("lw_edge.exec", 1'b1, 1'b0, 1'b0, 1'b0, alu_v(1'b1, 2'b00));
    repeat (15) step("lw_edge.mem", 1'b1, 1'b0, 1'b0, 1'b0, mem_v(1'b1, 1'b0));
    step("lw_edge.mem_rdy", 1'b1, 1'b0, 1'b0, 1'b1, mem_v(1'b1, 1'b0));
    step("lw_edge.wb", 1'b1, 1'b0, 1'b0, 1'b0, wb_v(2'b01, 2'b01));
    ret_m = ret_m + 32'd1;
    start("sw_to", 6'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    step("sw_to.exec", 1'b1, 1'b0, 1'b0, 1'b0, alu_v(1'b1, 2'b00));
    repeat (16) step("sw_to.mem", 1'b1, 1'b0, 1'b0, 1'b0, mem_v(1'b0, 1'b1));
    repeat (3) step("sw_to.trap", 1'b1, 1'b0, 1'b0, 1'b0, trap_v(2'b10));
    do_reset("sw_to");
    rtype("post");
    start("lw_rst", 6'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    step("lw_rst.exec", 1'b1, 1'b0, 1'b0, 1'b0, alu_v(1'b1, 2'b00));
    repeat (2) step("lw_rst.mem", 1'b1, 1'b0, 1'b0, 1'b0, mem_v(1'b1, 1'b0));
    do_reset("lw_rst");
    step("lw_rst.after", 1'b1, 1'b0, 1'b1, 1'b0, '0);
    start("ill9", 6'd9, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) step("ill9.trap", 1'b1, 1'b0, 1'b0, 1'b0, trap_v(2'b01));
    do_reset("ill9");
    start("bc3", 6'd5, 5'd3, 1'b0, 1'b0, 1'b0);
    repeat (2) step("bc3.trap", 1'b1, 1'b0, 1'b0, 1'b0, trap_v(2'b01));
    do_reset("bc3");
    rtype("final");
    step("final.idle", 1'b1, 1'b0, 1'b1, 1'b0, '0);
    run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
